// File: rtl/regwr_arb_if.sv
// regwr_arb_if: signal bundle between the write-port arbiter and its
// neighbours (writeback stage, long-latency unit, issue-stage scoreboard
// query and the register-file write port).
//
// Long-latency result handshake (lu_valid / lu_ready):
//   A result transfers on a clock edge where lu_valid && lu_ready are both
//   high. lu_ready depends only on arbiter state (FIFO not full), never on
//   lu_valid or on a same-cycle pop. The producer holds lu_valid, lu_wrreg
//   and lu_wrdata stable until the transfer happens.
interface regwr_arb_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // writeback stage (cannot be back-pressured)
  logic          wb_regwrite;
  logic [4:0]    wb_wrreg;
  logic [31:0]   wb_wrdata;
  // long-latency unit result
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_wrreg;
  logic [31:0]   lu_wrdata;
  // scoreboard query
  logic [4:0]    q_read1;
  logic [4:0]    q_read2;
  logic          pend1;
  logic          pend2;
  // register-file write port
  logic          regwrite;
  logic [4:0]    wrreg;
  logic [31:0]   wrdata;
  // status
  logic          pipe_stall;
  logic [CW-1:0] count;

  // environment side: drives requests, observes the arbiter
  modport master (
    output wb_regwrite, wb_wrreg, wb_wrdata,
    output lu_valid, lu_wrreg, lu_wrdata,
    output q_read1, q_read2,
    input  lu_ready, pend1, pend2,
    input  regwrite, wrreg, wrdata,
    input  pipe_stall, count
  );

  // arbiter side
  modport slave (
    input  wb_regwrite, wb_wrreg, wb_wrdata,
    input  lu_valid, lu_wrreg, lu_wrdata,
    input  q_read1, q_read2,
    output lu_ready, pend1, pend2,
    output regwrite, wrreg, wrdata,
    output pipe_stall, count
  );
endinterface

// File: rtl/regwr_arb.sv
// regwr_arb: shares the register file's single write port between the
// writeback stage and a long-latency result unit. Long-latency results are
// buffered in an in-order FIFO and drained into idle writeback slots. The
// block reports registers with buffered writes (pend1/pend2).
//
// Optional feature macro: REGWR_ARB_STARVE_EN
//   defined   -> starvation counter and registered pipe_stall request built
//   undefined -> no counter, pipe_stall tied low
module regwr_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic        clk,
  input logic        reset,
  regwr_arb_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // storage (data path, not reset: validity comes from pointers/count)
  logic [4:0]    ent_reg_q [DEPTH];
  logic [31:0]   ent_dat_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          wb_busy;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          accept;
  logic          push;
  logic [DEPTH-1:0] ent_valid;

  // Distance of slot idx from the read pointer, modulo DEPTH.
  function automatic logic [CW-1:0] slot_age(input logic [PW-1:0] idx,
                                             input logic [PW-1:0] rd);
    logic [PW-1:0] d;
    d = idx - rd;
    return {1'b0, d};
  endfunction

  // A wb write to r0 is treated as an idle slot.
  assign wb_busy    = bus.wb_regwrite && (bus.wb_wrreg != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  // Drain is suppressed while reset is held so no buffered write escapes.
  assign pop    = !reset && !wb_busy && !fifo_empty;
  assign accept = bus.lu_valid && !fifo_full;
  assign push   = accept && (bus.lu_wrreg != 5'd0);

  assign bus.lu_ready = !fifo_full;
  assign bus.count    = count_q;

  // Write-port mux: writeback first, else FIFO head, else idle zeros.
  always_comb begin
    bus.regwrite = 1'b0;
    bus.wrreg    = 5'd0;
    bus.wrdata   = 32'd0;
    if (wb_busy) begin
      bus.regwrite = 1'b1;
      bus.wrreg    = bus.wb_wrreg;
      bus.wrdata   = bus.wb_wrdata;
    end else if (pop) begin
      bus.regwrite = 1'b1;
      bus.wrreg    = ent_reg_q[rd_ptr_q];
      bus.wrdata   = ent_dat_q[rd_ptr_q];
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Per-slot valid bits derived from read pointer and occupancy.
  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = (slot_age(PW'(i), rd_ptr_q) < count_q);
    end
  end

  // Scoreboard: buffered entries (head included even when popping now)
  // plus any result being pushed this cycle.
  always_comb begin
    bus.pend1 = 1'b0;
    bus.pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_reg_q[i] == bus.q_read1)) bus.pend1 = 1'b1;
      if (ent_valid[i] && (ent_reg_q[i] == bus.q_read2)) bus.pend2 = 1'b1;
    end
    if (push && (bus.lu_wrreg == bus.q_read1)) bus.pend1 = 1'b1;
    if (push && (bus.lu_wrreg == bus.q_read2)) bus.pend2 = 1'b1;
    if (bus.q_read1 == 5'd0) bus.pend1 = 1'b0;
    if (bus.q_read2 == 5'd0) bus.pend2 = 1'b0;
  end

  // FIFO control state; reset flushes all buffered writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write on push.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[wr_ptr_q] <= bus.lu_wrreg;
      ent_dat_q[wr_ptr_q] <= bus.lu_wrdata;
    end
  end

`ifdef REGWR_ARB_STARVE_EN
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q,  stall_d;

  // Starvation counter and sticky stall request next-state.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (wb_busy && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    if (starve_q == SW'(STARVE_LIMIT)) begin
      stall_d = 1'b1;
    end else if (fifo_empty) begin
      stall_d = 1'b0;
    end
  end

  // Starvation state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.pipe_stall = stall_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign bus.pipe_stall      = 1'b0;
`endif

endmodule

// File: tb/tb_regwr_arb.sv
// tb_regwr_arb: self-checking bench for regwr_arb. Long-latency results
// are pushed onto an expected-write queue when an accepted result is
// driven, and popped/compared when the arbiter drains a write.
module tb_regwr_arb;

  localparam int DEPTH = 4;
`ifdef REGWR_ARB_STARVE_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  regwr_arb_if #(.DEPTH(DEPTH)) bus ();

  regwr_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];   // {wrreg, wrdata} of buffered long-latency writes
  logic        exp_stall;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pend_exp(input logic [4:0] q, input logic pushing,
                                    input logic [4:0] lr);
    logic p;
    p = 1'b0;
    if (q != 5'd0) begin
      foreach (exp_q[i]) if (exp_q[i][36:32] == q) p = 1'b1;
      if (pushing && lr == q) p = 1'b1;
    end
    return p;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of inputs, check outputs at negedge, update the model.
  task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] q1, input logic [4:0] q2);
    logic        busy;
    logic        rdy;
    logic [36:0] head;
    bus.wb_regwrite = wv;
    bus.wb_wrreg    = wr;
    bus.wb_wrdata   = wd;
    bus.lu_valid    = lv;
    bus.lu_wrreg    = lr;
    bus.lu_wrdata   = ld;
    bus.q_read1     = q1;
    bus.q_read2     = q2;
    @(negedge clk);
    busy = wv && (wr != 5'd0);
    rdy  = (exp_q.size() != DEPTH);
    check("count",      32'(bus.count), 32'(exp_q.size()));
    check("lu_ready",   32'(bus.lu_ready), 32'(rdy));
    check("pend1",      32'(bus.pend1), 32'(pend_exp(q1, lv && rdy, lr)));
    check("pend2",      32'(bus.pend2), 32'(pend_exp(q2, lv && rdy, lr)));
    check("pipe_stall", 32'(bus.pipe_stall), 32'(exp_stall));
    if (busy) begin
      check("wb_regwrite", 32'(bus.regwrite), 32'd1);
      check("wb_wrreg",    32'(bus.wrreg), 32'(wr));
      check("wb_wrdata",   bus.wrdata, wd);
    end else if (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check("lu_regwrite", 32'(bus.regwrite), 32'd1);
      check("lu_wrreg",    32'(bus.wrreg), 32'(head[36:32]));
      check("lu_wrdata",   bus.wrdata, head[31:0]);
    end else begin
      check("idle_regwrite", 32'(bus.regwrite), 32'd0);
    end
    if (lv && rdy && lr != 5'd0) exp_q.push_back({lr, ld});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
  endtask

  // Hold reset for n cycles with wb idle; no buffered write may appear.
  task automatic do_reset(input int n);
    reset           = 1'b1;
    bus.wb_regwrite = 1'b0;
    bus.wb_wrreg    = 5'd0;
    bus.wb_wrdata   = 32'd0;
    bus.lu_valid    = 1'b0;
    bus.lu_wrreg    = 5'd0;
    bus.lu_wrdata   = 32'd0;
    bus.q_read1     = 5'd0;
    bus.q_read2     = 5'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_regwrite", 32'(bus.regwrite), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_stall = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // reset values, including the idle-mux zeros on wrreg/wrdata
    @(negedge clk);
    check("rst_wrreg",  32'(bus.wrreg), 32'd0);
    check("rst_wrdata", bus.wrdata, 32'd0);
    @(posedge clk);
    #1;
    idle(1, 5'd3, 5'd0);

    // wb only
    cycle(1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);

    // lu path: pend in push cycle, write next cycle, pend drops after
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd0);
    idle(2, 5'd9, 5'd0);

    // fill with wb busy, 5th result held, then drain in order
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'd8, 32'h100 + i, 1'b1, 5'(10 + i), 32'hA000_0000 + i, 5'd13, 5'd12);
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 5'd8, 32'h200 + i, 1'b1, 5'd14, 32'hB000_0014, 5'd14, 5'd10);
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hB000_0014, 5'd14, 5'd12);
    idle(5, 5'd14, 5'd13);

    // r0 handling: discarded result, then wb r0 lets r5 drain
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);
    cycle(1'b1, 5'd8, 32'h300, 1'b1, 5'd5, 32'h0000_0555, 5'd5, 5'd0);
    cycle(1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(1, 5'd5, 5'd0);

    // starvation: one entry queued, wb busy continuously
    cycle(1'b1, 5'd8, 32'h400, 1'b1, 5'd20, 32'hA5A5_A5A5, 5'd20, 5'd0);
    for (int k = 0; k < 12; k++) begin
      exp_stall = STALL_EN && (k >= 9);
      cycle(1'b1, 5'd8, 32'h500 + k, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
    end
    exp_stall = STALL_EN;
    idle(2, 5'd20, 5'd0);
    exp_stall = 1'b0;
    idle(2, 5'd20, 5'd0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(6, 5'd0, 5'd0);

    // reset mid-traffic with 3 entries queued
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd8, 32'h600 + i, 1'b1, 5'(21 + i), 32'hC000_0000 + i, 5'd21, 5'd23);
    do_reset(2);
    idle(4, 5'd21, 5'd23);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
